// File: rtl/apb_slave_mem_responder.sv
// ----------------------------------------------------------------------------
// apb_slave_mem_responder
//
// APB4 completer that serves one PSEL line with a word-addressed memory.
// Writes honour PSTRB byte lanes. Each transfer has a programmable number of
// wait states. PSLVERR is returned for accesses that fall outside the window,
// are misaligned, or are reads with a non-zero PSTRB. A sticky flag records
// any master protocol violation that is seen.
//
// Ports
//   pclk            APB clock; all state changes on the rising edge
//   preset          asynchronous reset, active-high
//   psel            select for this completer
//   penable         access-phase indicator
//   pwrite          1 = write, 0 = read
//   paddr           byte address
//   pwdata          write data
//   pstrb           byte-lane write strobes
//   pprot           protection attributes (accepted and ignored)
//   cfg_wait_states wait states inserted per transfer (0..15)
//   pready          transfer completes in this cycle
//   prdata          read data, meaningful only while pready=1
//   pslverr         error response, meaningful only while pready=1
//   protocol_err    sticky master protocol-violation flag
// ----------------------------------------------------------------------------
module apb_slave_mem_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       MEM_DEPTH     = 3072,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [3:0]                cfg_wait_states,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    output logic                      protocol_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    // Values captured in the setup phase; the transfer always completes with these.
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic                       r_write;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [STRB_W-1:0]          r_strb;
    logic [IDX_W-1:0]           r_idx;

    logic [3:0]                 r_wait_cnt;
    logic                       r_err;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic                       r_prot_err;

    logic [DATA_WIDTH-1:0]      mem [MEM_DEPTH];

    logic [ADDRESS_WIDTH-1:0]   w_off;
    logic [ADDRESS_WIDTH-1:0]   w_idx_full;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_err;
    logic                       w_setup;
    logic                       w_abort;
    logic                       w_mismatch;
    logic                       w_complete;
    logic                       w_mem_we;
    logic                       w_unused;

    // pprot carries no function here; folded into a sink so it stays connected.
    assign w_unused   = ^pprot;

    // Address decode of the live bus, used only at the setup edge.
    assign w_off      = paddr - BASE_ADDR;
    assign w_idx_full = w_off >> LSB;
    assign w_idx      = w_idx_full[IDX_W-1:0];
    assign w_err      = (paddr < BASE_ADDR)
                      | (w_idx_full >= ADDRESS_WIDTH'(MEM_DEPTH))
                      | ((w_off & ADDRESS_WIDTH'(STRB_W - 1)) != '0)
                      | (!pwrite && (pstrb != '0));

    assign w_setup    = psel && !penable;
    // Losing either psel or penable mid-access is treated as an abandoned transfer.
    assign w_abort    = !psel || !penable;
    assign w_mismatch = (paddr != r_addr) || (pwrite != r_write) || (pwdata != r_wdata);
    assign w_complete = (r_state == ACCESS) && !w_abort && (r_wait_cnt == 4'd0);
    assign w_mem_we   = w_complete && r_write && !r_err;

    // Outputs decode from registers only, so pready has no input-to-output path.
    assign pready       = (r_state == ACCESS) && (r_wait_cnt == 4'd0);
    assign pslverr      = pready && r_err;
    assign prdata       = r_rdata;
    assign protocol_err = r_prot_err;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (w_abort || (r_wait_cnt == 4'd0)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_wait_cnt <= 4'd0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_prot_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_wait_cnt <= cfg_wait_states;
                        r_err      <= w_err;
                        // Read data is fetched at setup and held through the wait states.
                        r_rdata    <= (!pwrite && !w_err) ? mem[w_idx] : '0;
                    end else if (psel && penable) begin
                        r_prot_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (w_abort) begin
                        r_rdata    <= '0;
                        r_prot_err <= 1'b1;
                    end else begin
                        if (w_mismatch) begin
                            r_prot_err <= 1'b1;
                        end
                        if (r_wait_cnt != 4'd0) begin
                            r_wait_cnt <= r_wait_cnt - 4'd1;
                        end else begin
                            r_rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Captured request fields need no reset: they are only consumed in ACCESS.
    always_ff @(posedge pclk) begin
        if ((r_state == IDLE) && w_setup) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
            r_idx   <= w_idx;
        end
    end

    // Memory is never reset; a reset mid-transfer forces IDLE, which blocks the write.
    always_ff @(posedge pclk) begin
        if (w_mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (r_strb[i]) begin
                    mem[r_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
module tb_apb_slave_mem_responder;

    logic        pclk;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  cfg_wait_states;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   acc_cnt = 0;

    apb_slave_mem_responder #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_DEPTH     (3072),
        .BASE_ADDR     (32'h0)
    ) dut (
        .pclk            (pclk),
        .preset          (preset),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .pstrb           (pstrb),
        .pprot           (pprot),
        .cfg_wait_states (cfg_wait_states),
        .pready          (pready),
        .prdata          (prdata),
        .pslverr         (pslverr),
        .protocol_err    (protocol_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issues one transfer (setup + access) and returns once pready is seen.
    // The bus is left selected so another call follows with no idle cycle.
    task automatic xfer(input string nm, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_cyc);
        bit done;
        exp_t e;
        e.name = nm; e.rdata = exp_rd; e.err = exp_err; e.cycles = exp_cyc;
        sb.push_back(e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge pclk); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk);
            if (pready) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: pready never rose within 40 cycles", nm);
        end
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Scoreboard monitor: every completion must match the oldest expectation.
    always @(negedge pclk) begin
        if (preset) begin
            acc_cnt = 0;
        end else if (pready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pready: prdata %h pslverr %0d, no transfer expected", prdata, pslverr);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_prdata"},  prdata, mon_e.rdata);
                chk({mon_e.name, "_pslverr"}, {31'd0, pslverr}, {31'd0, mon_e.err});
                chk({mon_e.name, "_cycles"},  acc_cnt + 1, mon_e.cycles);
            end
            acc_cnt = 0;
        end else if (psel && penable) begin
            acc_cnt++;
        end else begin
            acc_cnt = 0;
        end
    end

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b000; cfg_wait_states = 4'd0;

        repeat (2) @(posedge pclk);
        #1;
        chk("rst_pready",   {31'd0, pready},       32'd0);
        chk("rst_prdata",   prdata,                32'd0);
        chk("rst_pslverr",  {31'd0, pslverr},      32'd0);
        chk("rst_proterr",  {31'd0, protocol_err}, 32'd0);
        @(posedge pclk); #1;
        preset = 1'b0;

        // Full write then back-to-back read.
        xfer("t1_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1);
        xfer("t1_rd", 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1);
        idle();

        // Partial-strobe write merges lanes 0 and 2 only.
        xfer("t2_wr", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0,        1'b0, 1);
        xfer("t2_rd", 1'b0, 32'h10, 32'h0,        4'h0,    32'hDE22BE44, 1'b0, 1);
        idle();

        // Three wait states: four access cycles.
        cfg_wait_states = 4'd3;
        xfer("t3_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 4);
        idle();
        cfg_wait_states = 4'd0;

        // Error responses and window boundaries.
        xfer("t4_rd_oor",   1'b0, 32'h3000, 32'h0,        4'h0, 32'h0,        1'b1, 1);
        xfer("t4_wr_mis",   1'b1, 32'h12,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1);
        xfer("t4_rd_chk",   1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0, 1);
        xfer("t4_rd_strb",  1'b0, 32'h10,   32'h0,        4'hF, 32'h0,        1'b1, 1);
        xfer("t4_wr_last",  1'b1, 32'h2FFC, 32'hA5A55A5A, 4'hF, 32'h0,        1'b0, 1);
        xfer("t4_rd_last",  1'b0, 32'h2FFC, 32'h0,        4'h0, 32'hA5A55A5A, 1'b0, 1);
        xfer("t6_pre_wr",   1'b1, 32'h20,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1);
        idle();
        @(negedge pclk);
        chk("t4_proterr_clear", {31'd0, protocol_err}, 32'd0);

        // Master drops penable mid-access: abort, no write, sticky flag.
        cfg_wait_states = 4'd2;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b0;
        @(negedge pclk);
        chk("t5_proterr",  {31'd0, protocol_err}, 32'd1);
        chk("t5_pready",   {31'd0, pready},       32'd0);
        cfg_wait_states = 4'd0;
        xfer("t5_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1);
        idle();
        @(negedge pclk);
        chk("t5_proterr_sticky", {31'd0, protocol_err}, 32'd1);

        // Reset during wait states: outputs clear at once, write discarded.
        cfg_wait_states = 4'd5;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk);
        @(posedge pclk); #3;
        preset = 1'b1;
        #1;
        chk("t6_pready",  {31'd0, pready},       32'd0);
        chk("t6_prdata",  prdata,                32'd0);
        chk("t6_pslverr", {31'd0, pslverr},      32'd0);
        chk("t6_proterr", {31'd0, protocol_err}, 32'd0);
        psel = 1'b0; penable = 1'b0; cfg_wait_states = 4'd0;
        @(posedge pclk); #1;
        preset = 1'b0;
        xfer("t6_rd", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1);
        idle();
        @(posedge pclk);
        @(negedge pclk);

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
